// File: rtl/gray_conv_arbiter.sv
// Two-requester RGB-to-grayscale converter: a round-robin burst arbiter feeding a
// 2-stage multiply/sum pipeline with global backpressure and a burst-length cap.
module gray_conv_arbiter #(
    parameter int MAX_BURST = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] s0_rgb,
    input  logic [23:0] s1_rgb,
    input  logic        s0_valid,
    input  logic        s1_valid,
    input  logic        s0_last,
    input  logic        s1_last,
    output logic        s0_ready,
    output logic        s1_ready,
    output logic [7:0]  m_gray,
    output logic        m_valid,
    output logic        m_last,
    output logic        m_id,
    input  logic        m_ready,
    output logic        busy,
    output logic        cut_pulse
);

    typedef enum logic [1:0] {
        IDLE,
        SERVE0,
        SERVE1
    } state_t;

    localparam logic [15:0] LIMIT = 16'(MAX_BURST - 1);

    state_t      state, state_next;
    logic        ptr, ptr_next;
    logic [15:0] bcnt, bcnt_next;

    logic        stage1_valid, stage1_last, stage1_id;
    logic [15:0] p_r, p_g, p_b;
    logic [16:0] sum;

    logic        advance, sel_id, sel_last, accept, at_limit, burst_end;
    logic [23:0] sel_rgb;

    // A full stage1 blocked by a stalled output freezes the whole pipeline.
    always_comb begin
        advance   = !stage1_valid || !m_valid || m_ready;
        sel_id    = (state == SERVE1);
        sel_rgb   = sel_id ? s1_rgb : s0_rgb;
        sel_last  = sel_id ? s1_last : s0_last;
        s0_ready  = (state == SERVE0) && advance;
        s1_ready  = (state == SERVE1) && advance;
        accept    = (s0_valid && s0_ready) || (s1_valid && s1_ready);
        at_limit  = (bcnt == LIMIT);
        burst_end = accept && (sel_last || at_limit);
        cut_pulse = accept && at_limit && !sel_last;
        busy      = (state != IDLE) || stage1_valid || m_valid;
        sum       = 17'(p_r) + 17'(p_g) + 17'(p_b) + 17'd128;
    end

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        bcnt_next  = bcnt;
        case (state)
            IDLE: begin
                if (s0_valid && s1_valid) state_next = ptr ? SERVE1 : SERVE0;
                else if (s0_valid)        state_next = SERVE0;
                else if (s1_valid)        state_next = SERVE1;
            end
            SERVE0, SERVE1: begin
                if (burst_end) begin
                    state_next = IDLE;
                    ptr_next   = !sel_id;
                    bcnt_next  = '0;
                end else if (accept) begin
                    bcnt_next = bcnt + 16'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= 1'b0;
            bcnt  <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
            bcnt  <= bcnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage1_valid <= 1'b0;
            stage1_last  <= 1'b0;
            stage1_id    <= 1'b0;
            p_r          <= '0;
            p_g          <= '0;
            p_b          <= '0;
            m_valid      <= 1'b0;
            m_gray       <= '0;
            m_last       <= 1'b0;
            m_id         <= 1'b0;
        end else begin
            if (advance) begin
                stage1_valid <= accept;
                if (accept) begin
                    p_r         <= 16'(sel_rgb[23:16]) * 16'd77;
                    p_g         <= 16'(sel_rgb[15:8])  * 16'd150;
                    p_b         <= 16'(sel_rgb[7:0])   * 16'd29;
                    stage1_id   <= sel_id;
                    stage1_last <= sel_last || at_limit;
                end
            end
            // Output stage refills whenever it is empty or being drained.
            if (!m_valid || m_ready) begin
                m_valid <= stage1_valid;
                if (stage1_valid) begin
                    m_gray <= 8'(sum >> 8);
                    m_id   <= stage1_id;
                    m_last <= stage1_last;
                end
            end
        end
    end

endmodule
